// File: rtl/mux_2x1.sv
// Parameterised 2:1 select with optional output register and a simulation-only
// select-error flag. Port order keeps legacy (y, i0, i1, sel) instances intact.
module mux_2x1 #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b0
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    input  logic             clk,
    input  logic             rst_n,
    output logic             sel_err
);

    logic [WIDTH-1:0] mux_d;

    // The conditional operator already merges i0/i1 bitwise on an unknown
    // select, so equal known bits survive and differing bits go X.
    assign mux_d = sel ? i1 : i0;

`ifndef SYNTHESIS
    assign sel_err = $isunknown(sel);
`else
    assign sel_err = 1'b0;
`endif

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] y_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    y_q <= '0;
                end else begin
                    y_q <= mux_d;
                end
            end

            assign y = y_q;
        end else begin : g_comb
            // Clock and reset have no load in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst_n};

            assign y = mux_d;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2x1.sv
// Directed bench for mux_2x1: combinational W=1 and W=4 builds, registered W=8 build.
module tb_mux_2x1;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_i0, a_i1, a_sel, a_y, a_err;
    logic [3:0] b_i0, b_i1, b_y;
    logic       b_sel, b_err;
    logic [7:0] c_i0, c_i1, c_y;
    logic       c_sel, c_err;

    int checks = 0;
    int errors = 0;
    bit four_state;

    always #5 clk = ~clk;

    mux_2x1 #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (
        .y(a_y), .i0(a_i0), .i1(a_i1), .sel(a_sel),
        .clk(clk), .rst_n(rst_n), .sel_err(a_err)
    );

    mux_2x1 #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
        .y(b_y), .i0(b_i0), .i1(b_i1), .sel(b_sel),
        .clk(clk), .rst_n(rst_n), .sel_err(b_err)
    );

    mux_2x1 #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .y(c_y), .i0(c_i0), .i1(c_i1), .sel(c_sel),
        .clk(clk), .rst_n(rst_n), .sel_err(c_err)
    );

    task automatic test_reset();
        c_i0 = 8'h00; c_i1 = 8'hA5; c_sel = 1'b1; rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (c_y !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected 00", k, c_y);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (c_y !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_pre_edge: got %h expected 00", c_y);
        end
        @(posedge clk); #1;
        checks++;
        if (c_y !== 8'hA5) begin
            errors++;
            $display("FAIL reset_release: got %h expected a5", c_y);
        end
        checks++;
        if (c_err !== 1'b0) begin
            errors++;
            $display("FAIL reg_sel_err: got %b expected 0", c_err);
        end
    endtask

    task automatic test_comb_w1();
        // {i0, i1, sel, expected y}
        logic [3:0] vec [6] = '{4'b0111, 4'b1101, 4'b1111, 4'b0010, 4'b1001, 4'b1010};
        for (int k = 0; k < 6; k++) begin
            {a_i0, a_i1, a_sel} = vec[k][3:1];
            #1;
            checks++;
            if (a_y !== vec[k][0]) begin
                errors++;
                $display("FAIL w1_select[%0d]: got %b expected %b", k, a_y, vec[k][0]);
            end
            checks++;
            if (a_err !== 1'b0) begin
                errors++;
                $display("FAIL w1_sel_err[%0d]: got %b expected 0", k, a_err);
            end
        end
    endtask

    task automatic test_comb_w4();
        b_i0 = 4'b1010; b_i1 = 4'b1001;
        b_sel = 1'b0; #1;
        checks++;
        if (b_y !== 4'b1010) begin
            errors++;
            $display("FAIL w4_sel0: got %b expected 1010", b_y);
        end
        b_sel = 1'b1; #1;
        checks++;
        if (b_y !== 4'b1001) begin
            errors++;
            $display("FAIL w4_sel1: got %b expected 1001", b_y);
        end
    endtask

    // Unknown-select behaviour only exists on a four-state simulator.
    task automatic test_unknown_sel();
        if (!four_state) begin
            $display("note: two-state simulator, unknown-select vectors skipped");
        end else begin
            a_i0 = 1'b0; a_i1 = 1'b1; a_sel = 1'bx; #1;
            checks++;
            if (a_y !== 1'bx || a_err !== 1'b1) begin
                errors++;
                $display("FAIL w1_sel_x: got y=%b err=%b expected y=x err=1", a_y, a_err);
            end
            a_sel = 1'bz; #1;
            checks++;
            if (a_y !== 1'bx || a_err !== 1'b1) begin
                errors++;
                $display("FAIL w1_sel_z: got y=%b err=%b expected y=x err=1", a_y, a_err);
            end
            a_i0 = 1'b1; a_i1 = 1'b1; a_sel = 1'bx; #1;
            checks++;
            if (a_y !== 1'b1 || a_err !== 1'b1) begin
                errors++;
                $display("FAIL w1_sel_x_merge: got y=%b err=%b expected y=1 err=1", a_y, a_err);
            end
            b_i0 = 4'b1010; b_i1 = 4'b1001; b_sel = 1'bx; #1;
            checks++;
            if (b_y !== 4'b10xx || b_err !== 1'b1) begin
                errors++;
                $display("FAIL w4_sel_x_merge: got y=%b err=%b expected y=10xx err=1", b_y, b_err);
            end
            a_sel = 1'b0; b_sel = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] prev = 8'hA5;
        logic [7:0] exp_y;
        c_i0 = 8'h3C; c_i1 = 8'hC3;
        for (int k = 0; k < 6; k++) begin
            c_sel = k[0];
            exp_y = c_sel ? 8'hC3 : 8'h3C;
            #1;
            checks++;
            if (c_y !== prev) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: got %h expected %h", k, c_y, prev);
            end
            @(posedge clk); #1;
            checks++;
            if (c_y !== exp_y) begin
                errors++;
                $display("FAIL b2b_follow[%0d]: got %h expected %h", k, c_y, exp_y);
            end
            prev = exp_y;
        end
        c_sel = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (c_y !== 8'h00) begin
            errors++;
            $display("FAIL b2b_mid_reset: got %h expected 00", c_y);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (c_y !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_resume: got %h expected c3", c_y);
        end
    endtask

    initial begin
        logic probe;
        probe = 1'bx;
        four_state = (probe !== 1'b0) && (probe !== 1'b1);
        a_i0 = 1'b0; a_i1 = 1'b0; a_sel = 1'b0;
        b_i0 = 4'h0; b_i1 = 4'h0; b_sel = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_comb_w1();
        test_comb_w4();
        test_unknown_sel();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
